// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter_pkg
//  Purpose  : Shared kind encodings, FSM states and limits for shift_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package shift_arbiter_pkg;

  // Shift kind encodings carried on reqN_kind
  localparam logic [2:0] KIND_LSL = 3'b000;
  localparam logic [2:0] KIND_LSR = 3'b001;
  localparam logic [2:0] KIND_ASL = 3'b010;
  localparam logic [2:0] KIND_ASR = 3'b011;
  localparam logic [2:0] KIND_ROL = 3'b100;
  localparam logic [2:0] KIND_ROR = 3'b101;

  // Largest shift amount the datapath supports
  localparam int MAX_COUNT = 7;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Kinds above ROR are unassigned encodings
  function automatic logic kind_is_legal(input logic [2:0] kind);
    return (kind <= KIND_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_shift_core.sv
`default_nettype none
// ============================================================================
//  Module   : shift_core
//  Purpose  : Combinational 8-bit funnel shifter. Every kind is expressed as a
//             right shift of a 16-bit window; left shifts shift the window
//             {data, low_fill} right by (8 - count).
//  Revision : 1.0 - initial release
// ============================================================================
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [2:0] kind,
  input  logic [3:0] count,
  input  logic [7:0] data,
  output logic [7:0] result,
  output logic       illegal
);

  logic [15:0] w_window;
  logic [3:0]  w_amount;
  logic [15:0] w_shifted;

  // Build the funnel window and the right-shift amount for the selected kind
  always_comb begin
    w_window = 16'h0000;
    w_amount = 4'd0;
    case (kind)
      KIND_LSL, KIND_ASL: begin
        w_window = {data, 8'h00};
        w_amount = 4'd8 - count;
      end
      KIND_ROL: begin
        w_window = {data, data};
        w_amount = 4'd8 - count;
      end
      KIND_LSR: begin
        w_window = {8'h00, data};
        w_amount = count;
      end
      KIND_ASR: begin
        w_window = {{8{data[7]}}, data};
        w_amount = count;
      end
      KIND_ROR: begin
        w_window = {data, data};
        w_amount = count;
      end
      default: begin
        w_window = 16'h0000;
        w_amount = 4'd0;
      end
    endcase
  end

  assign w_shifted = w_window >> w_amount;

  // Illegal operations deliver a zero result alongside the error flag
  always_comb begin
    illegal = !kind_is_legal(kind) || (count > 4'(MAX_COUNT));
    result  = illegal ? 8'h00 : w_shifted[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Round-robin sequencer sharing one shift_core between two
//             requesters; registered result returned over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_kind,
  input  logic [3:0] req0_count,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_kind,
  input  logic [3:0] req1_count,
  input  logic [7:0] req1_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic       out_err,
  output logic       busy
);

  state_t     r_state;
  logic       r_prio;
  logic [2:0] r_op_kind;
  logic [3:0] r_op_count;
  logic [7:0] r_op_data;
  logic       r_op_id;

  logic       w_can_accept;
  logic [7:0] w_core_result;
  logic       w_core_illegal;

  // Ready is held low while reset is asserted so nothing is accepted then
  assign w_can_accept = (r_state == ST_IDLE) && !rst;
  assign req0_ready   = w_can_accept && req0_valid && (!req1_valid || (r_prio == 1'b0));
  assign req1_ready   = w_can_accept && req1_valid && (!req0_valid || (r_prio == 1'b1));
  assign busy         = (r_state != ST_IDLE);

  shift_core u_shift_core (
    .kind    (r_op_kind),
    .count   (r_op_count),
    .data    (r_op_data),
    .result  (w_core_result),
    .illegal (w_core_illegal)
  );

  // Sequencer: capture granted operation, compute once, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prio     <= RR_INIT;
      r_op_kind  <= 3'b000;
      r_op_count <= 4'd0;
      r_op_data  <= 8'h00;
      r_op_id    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_id     <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req0_valid && req0_ready) begin
            r_op_kind  <= req0_kind;
            r_op_count <= req0_count;
            r_op_data  <= req0_data;
            r_op_id    <= 1'b0;
            r_state    <= ST_EXEC;
          end else if (req1_valid && req1_ready) begin
            r_op_kind  <= req1_kind;
            r_op_count <= req1_count;
            r_op_data  <= req1_data;
            r_op_id    <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_data  <= w_core_result;
          out_err   <= w_core_illegal;
          out_id    <= r_op_id;
          out_valid <= 1'b1;
          // The requester just served loses the next tie
          r_prio    <= ~r_op_id;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
